// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings and ALU operation codes shared by decode and execute.
package mips_pkg;
  localparam int NB_REG = 5;
  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_ADDIU = 6'b001001,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_XORI  = 6'b001110,
    OP_LUI   = 6'b001111,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_t;
  typedef enum logic [5:0] {
    ALU_SRL  = 6'b000010,
    ALU_SRA  = 6'b000011,
    ALU_ADD  = 6'b100000,
    ALU_SUB  = 6'b100010,
    ALU_AND  = 6'b100100,
    ALU_OR   = 6'b100101,
    ALU_XOR  = 6'b100110,
    ALU_NOR  = 6'b100111
  } alu_code_t;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
endpackage

// File: rtl/id_alu_ctrl_if.sv
// id_alu_ctrl_if: instruction/operand inputs and registered ALU-control outputs of the ID/EX stage.
interface id_alu_ctrl_if #(parameter int NB_OP = 6, NB_DATA = 32, NB_CNT = 8);
  logic               i_valid;
  logic [31:0]        i_instr;
  logic [NB_DATA-1:0] i_rs_data;
  logic [NB_DATA-1:0] i_rt_data;
  logic               i_stall;
  logic               i_flush;
  logic               o_valid;
  logic [NB_OP-1:0]   o_alu_code;
  logic [NB_DATA-1:0] o_data_1;
  logic [NB_DATA-1:0] o_data_2;
  logic               o_wr_en;
  logic [4:0]         o_wr_addr;
  logic               o_illegal;
  logic [NB_CNT-1:0]  o_illegal_cnt;
  modport master (
    output i_valid, i_instr, i_rs_data, i_rt_data, i_stall, i_flush,
    input  o_valid, o_alu_code, o_data_1, o_data_2, o_wr_en, o_wr_addr, o_illegal, o_illegal_cnt
  );
  modport slave (
    input  i_valid, i_instr, i_rs_data, i_rt_data, i_stall, i_flush,
    output o_valid, o_alu_code, o_data_1, o_data_2, o_wr_en, o_wr_addr, o_illegal, o_illegal_cnt
  );
endinterface

// File: rtl/id_alu_decode.sv
// id_alu_decode: combinational instruction decode into ALU code, operands and writeback target.
module id_alu_decode
  import mips_pkg::*;
#(
  parameter int NB_OP   = 6,
  parameter int NB_DATA = 32
) (
  input  logic [31:0]        instr,
  input  logic [NB_DATA-1:0] rs_data,
  input  logic [NB_DATA-1:0] rt_data,
  output logic [NB_OP-1:0]   code,
  output logic [NB_DATA-1:0] data_1,
  output logic [NB_DATA-1:0] data_2,
  output logic               wr_en,
  output logic [NB_REG-1:0]  wr_addr,
  output logic               illegal
);
  logic [5:0]         op, funct;
  logic [NB_REG-1:0]  rt, rd;
  logic [4:0]         shamt;
  logic [15:0]        imm;
  logic [NB_DATA-1:0] imm_sx, imm_zx, shamt_zx;
  logic               wen;
  assign op       = instr[31:26];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_sx   = {{(NB_DATA-16){imm[15]}}, imm};
  assign imm_zx   = {{(NB_DATA-16){1'b0}}, imm};
  assign shamt_zx = {{(NB_DATA-5){1'b0}}, shamt};
  always_comb begin
    code    = '0;
    data_1  = '0;
    data_2  = '0;
    wen     = 1'b0;
    wr_addr = '0;
    illegal = 1'b0;
    if (instr != 32'h0)
      case (op)
        OP_RTYPE:
          case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR: begin
              code = NB_OP'(funct); data_1 = rs_data; data_2 = rt_data; wen = 1'b1; wr_addr = rd;
            end
            FN_SRL, FN_SRA: begin
              code = NB_OP'(funct); data_1 = rt_data; data_2 = shamt_zx; wen = 1'b1; wr_addr = rd;
            end
            FN_SRLV, FN_SRAV: begin
              code = (funct == FN_SRLV) ? NB_OP'(ALU_SRL) : NB_OP'(ALU_SRA);
              data_1 = rt_data; data_2 = rs_data; wen = 1'b1; wr_addr = rd;
            end
            default: illegal = 1'b1;
          endcase
        OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
          code = NB_OP'(ALU_ADD); data_1 = rs_data; data_2 = imm_sx; wen = (op != OP_SW); wr_addr = rt;
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          code = (op == OP_ANDI) ? NB_OP'(ALU_AND) : (op == OP_ORI) ? NB_OP'(ALU_OR) : NB_OP'(ALU_XOR);
          data_1 = rs_data; data_2 = imm_zx; wen = 1'b1; wr_addr = rt;
        end
        OP_LUI: begin
          code = NB_OP'(ALU_OR); data_2 = {imm, {(NB_DATA-16){1'b0}}}; wen = 1'b1; wr_addr = rt;
        end
        OP_BEQ, OP_BNE: begin
          code = NB_OP'(ALU_SUB); data_1 = rs_data; data_2 = rt_data;
        end
        default: illegal = 1'b1;
      endcase
  end
  // writes to $zero are architecturally discarded
  assign wr_en = wen && (wr_addr != '0);
endmodule

// File: rtl/id_alu_ctrl.sv
// id_alu_ctrl: ALU control decode plus ID/EX pipeline register with stall/flush and illegal counter.
module id_alu_ctrl
  import mips_pkg::*;
#(
  parameter int NB_OP   = 6,
  parameter int NB_DATA = 32,
  parameter int NB_CNT  = 8
) (
  input logic          i_clk,
  input logic          i_reset,
  id_alu_ctrl_if.slave bus
);
  logic [NB_OP-1:0]   dec_code;
  logic [NB_DATA-1:0] dec_d1, dec_d2;
  logic               dec_wr_en, dec_illegal;
  logic [NB_REG-1:0]  dec_wr_addr;
  logic               bubble, load;
  id_alu_decode #(.NB_OP(NB_OP), .NB_DATA(NB_DATA)) u_decode (
    .instr   (bus.i_instr),
    .rs_data (bus.i_rs_data),
    .rt_data (bus.i_rt_data),
    .code    (dec_code),
    .data_1  (dec_d1),
    .data_2  (dec_d2),
    .wr_en   (dec_wr_en),
    .wr_addr (dec_wr_addr),
    .illegal (dec_illegal)
  );
  // flush outranks stall; an unstalled edge without a valid instruction is also a bubble
  assign bubble = i_reset || bus.i_flush || (!bus.i_stall && !bus.i_valid);
  assign load   = !i_reset && !bus.i_flush && !bus.i_stall && bus.i_valid;
  always_ff @(posedge i_clk) begin
    if (bubble) begin
      bus.o_valid    <= 1'b0;
      bus.o_alu_code <= '0;
      bus.o_data_1   <= '0;
      bus.o_data_2   <= '0;
      bus.o_wr_en    <= 1'b0;
      bus.o_wr_addr  <= '0;
      bus.o_illegal  <= 1'b0;
    end else if (load) begin
      bus.o_valid    <= 1'b1;
      bus.o_alu_code <= dec_code;
      bus.o_data_1   <= dec_d1;
      bus.o_data_2   <= dec_d2;
      bus.o_wr_en    <= dec_wr_en;
      bus.o_wr_addr  <= dec_wr_addr;
      bus.o_illegal  <= dec_illegal;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) bus.o_illegal_cnt <= '0;
    else if (load && dec_illegal && !(&bus.o_illegal_cnt)) bus.o_illegal_cnt <= bus.o_illegal_cnt + 1'b1;
  end
endmodule

// File: tb/tb_id_alu_ctrl.sv
// tb_id_alu_ctrl: directed-vector bench for the ID/EX ALU control stage.
module tb_id_alu_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt;
  always #5 clk = ~clk;
  id_alu_ctrl_if #(.NB_OP(6), .NB_DATA(32), .NB_CNT(8)) bus ();
  id_alu_ctrl #(.NB_OP(6), .NB_DATA(32), .NB_CNT(8)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic st, input logic fl,
                      input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    rst = r; bus.i_valid = v; bus.i_stall = st; bus.i_flush = fl;
    bus.i_instr = ins; bus.i_rs_data = rs; bus.i_rt_data = rt;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input logic v, input logic [5:0] c,
                            input logic [31:0] d1, input logic [31:0] d2, input logic w,
                            input logic [4:0] wa, input logic il, input logic [7:0] cn);
    chk({tag, ".valid"}, 32'(bus.o_valid), 32'(v));
    chk({tag, ".code"}, 32'(bus.o_alu_code), 32'(c));
    chk({tag, ".d1"}, bus.o_data_1, d1);
    chk({tag, ".d2"}, bus.o_data_2, d2);
    chk({tag, ".wr_en"}, 32'(bus.o_wr_en), 32'(w));
    chk({tag, ".wr_addr"}, 32'(bus.o_wr_addr), 32'(wa));
    chk({tag, ".illegal"}, 32'(bus.o_illegal), 32'(il));
    chk({tag, ".cnt"}, 32'(bus.o_illegal_cnt), 32'(cn));
  endtask
  initial begin
    step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    expect_out("reset", 0, 6'h00, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h2022FFFF, 32'd5, 32'd9);
    expect_out("addi", 1, 6'b100000, 32'd5, 32'hFFFFFFFF, 1, 5'd2, 0, 0);
    step(0, 1, 0, 0, 32'h00032103, 32'h1, 32'h80000000);
    expect_out("sra", 1, 6'b000011, 32'h80000000, 32'd4, 1, 5'd4, 0, 0);
    step(0, 1, 0, 0, 32'h3C051234, 32'hAAAA5555, 32'h1);
    expect_out("lui", 1, 6'b100101, 32'h0, 32'h12340000, 1, 5'd5, 0, 0);
    step(0, 1, 0, 0, 32'h00220020, 32'd7, 32'd9);
    expect_out("add_r0", 1, 6'b100000, 32'd7, 32'd9, 0, 5'd0, 0, 0);
    step(0, 1, 0, 0, 32'hAC22FFFC, 32'd10, 32'd3);
    expect_out("sw", 1, 6'b100000, 32'd10, 32'hFFFFFFFC, 0, 5'd2, 0, 0);
    step(0, 1, 0, 0, 32'h00432006, 32'd3, 32'hF0000000);
    expect_out("srlv", 1, 6'b000010, 32'hF0000000, 32'd3, 1, 5'd4, 0, 0);
    step(0, 1, 0, 0, 32'h10220005, 32'd8, 32'd6);
    expect_out("beq", 1, 6'b100010, 32'd8, 32'd6, 0, 5'd0, 0, 0);
    step(0, 1, 0, 0, 32'h3023F0F0, 32'hFFFF1234, 32'd0);
    expect_out("andi", 1, 6'b100100, 32'hFFFF1234, 32'h0000F0F0, 1, 5'd3, 0, 0);
    step(0, 1, 0, 0, 32'h0, 32'd4, 32'd4);
    expect_out("nop", 1, 6'h00, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 32'h2022FFFF, 32'd5, 32'd5);
    expect_out("invalid", 0, 6'h00, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h2022FFFF, 32'd5, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 32'h3C051234 + i, 32'd77, 32'd88);
      expect_out("stall", 1, 6'b100000, 32'd5, 32'hFFFFFFFF, 1, 5'd2, 0, 0);
    end
    step(0, 1, 1, 1, 32'h3C051234, 32'd77, 32'd88);
    expect_out("stall_flush", 0, 6'h00, 0, 0, 0, 0, 0, 0);
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 32'hFC000000, 32'd1, 32'd2);
      exp_cnt++;
      expect_out("illegal", 1, 6'h00, 0, 0, 0, 0, 1, 8'(exp_cnt));
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 0, 32'hFC000000, 32'd1, 32'd2);
      chk("illegal_stall.cnt", 32'(bus.o_illegal_cnt), 32'd5);
    end
    step(0, 1, 0, 1, 32'hFC000000, 32'd1, 32'd2);
    expect_out("illegal_flush", 0, 6'h00, 0, 0, 0, 0, 0, 8'd5);
    for (int i = 0; i < 295; i++) begin
      step(0, 1, 0, 0, 32'hFC000000, 32'd1, 32'd2);
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      chk("illegal_run.ill", 32'(bus.o_illegal), 32'd1);
      chk("illegal_run.cnt", 32'(bus.o_illegal_cnt), 32'(exp_cnt));
    end
    chk("illegal_sat", 32'(bus.o_illegal_cnt), 32'd255);
    step(0, 1, 1, 0, 32'h2022FFFF, 32'd5, 32'd0);
    step(1, 1, 1, 0, 32'h2022FFFF, 32'd5, 32'd0);
    expect_out("reset_in_stall", 0, 6'h00, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h2022FFFF, 32'd5, 32'd0);
    step(0, 1, 0, 0, 32'h3C051234, 32'd5, 32'd0);
    step(1, 1, 0, 0, 32'h3C051234, 32'd5, 32'd0);
    expect_out("reset_stream", 0, 6'h00, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h2022FFFF, 32'd11, 32'd0);
    expect_out("after_reset", 1, 6'b100000, 32'd11, 32'hFFFFFFFF, 1, 5'd2, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_alu_ctrl.md
# id_alu_ctrl

Instruction-decode-side ALU control and ID/EX pipeline register for the MIPS core. Decodes a 32-bit instruction into the 6-bit ALU operation code and selected operands, then registers them with valid/stall/flush control. Feeds the execute-stage ALU directly. Its operation codes are the ALU's funct-style encodings.

## Interface
- NB_OP, 6, ALU operation code width
- NB_DATA, 32, operand/data width
- NB_REG, 5, register address width
- NB_CNT, 8, illegal-instruction counter width

- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  i_instr/i_rs_data/i_rt_data are a real instruction
- i_instr  in  32  instruction word
- i_rs_data  in  NB_DATA  register-file value of rs
- i_rt_data  in  NB_DATA  register-file value of rt
- i_stall  in  1  hold all registered outputs
- i_flush  in  1  replace the stage contents with a bubble
- o_valid  out  1  outputs carry a real instruction
- o_alu_code  out  NB_OP  ALU operation code
- o_data_1  out  NB_DATA  ALU operand 1
- o_data_2  out  NB_DATA  ALU operand 2
- o_wr_en  out  1  result writes to the register file
- o_wr_addr  out  NB_REG  destination register
- o_illegal  out  1  registered instruction is unsupported
- o_illegal_cnt  out  NB_CNT  saturating count of accepted illegal instructions

## Operation
- ALU codes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011.
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
- R-type (op 000000):
  - funct ADD/SUB/AND/OR/XOR/NOR: code=funct, d1=rs_data, d2=rt_data, wr=rd.
  - funct 000010/000011 (SRL/SRA): code=funct, d1=rt_data, d2=zero-extended shamt, wr=rd.
  - funct 000110 (SRLV): code=SRL, d1=rt_data, d2=rs_data, wr=rd.
  - funct 000111 (SRAV): code=SRA, d1=rt_data, d2=rs_data, wr=rd.
- ADDI 001000 and ADDIU 001001: ADD, d1=rs_data, d2=sign-extended imm, wr=rt.
- ANDI 001100, ORI 001101, XORI 001110: AND/OR/XOR, d1=rs_data, d2=zero-extended imm, wr=rt.
- LUI 001111: OR, d1=0, d2={imm,16'h0}, wr=rt.
- LW 100011: ADD, d1=rs_data, d2=sign-extended imm, wr=rt.
- SW 101011: same as LW, wr_en=0.
- BEQ 000100 and BNE 000101: SUB, d1=rs_data, d2=rt_data, wr_en=0.
- i_instr==32'h0 (NOP): code 000000, operands 0, wr_en=0, illegal=0.
- Anything else is illegal: code 000000, operands 0, wr_en=0, illegal=1.
- o_wr_en is forced 0 whenever the destination is register 0.
- Register update priority, per rising edge: i_reset > i_flush > i_stall > load.
  - Load with i_valid=1: decoded values are registered and o_valid=1.
  - Load with i_valid=0: bubble.
- Bubble: o_valid=0 and every other registered output 0.
- o_illegal_cnt increments on a load with i_valid=1 and illegal decode; it saturates at 2^NB_CNT-1.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Reset: every output, including o_illegal_cnt, is 0 on the cycle after an edge with i_reset=1. Reset mid-stall also clears.
- Stall: outputs and counter hold for every stalled edge. Inputs presented during a stall are dropped; the upstream stage re-presents them.
- Stall and flush asserted together: flush wins and a bubble is loaded. The counter does not increment on flush or stall edges.
- The decode path is fully combinational from i_instr. No multicycle paths.

## Structure
- Package mips_pkg holds:
  - Opcode and funct constants.
  - ALU operation code constants, shared with the execute-stage ALU.
  - NB_REG.
- Sub-module id_alu_decode is the pure combinational decoder: instr and register data in, code/operands/wr_en/wr_addr/illegal out.
- id_alu_ctrl instantiates id_alu_decode and adds the pipeline register and counter.

## Test plan
- ADDI 0x2022FFFF, rs_data=5 -> next cycle: code 100000, d1=5, d2=0xFFFFFFFF, wr_en=1, wr_addr=2, o_valid=1.
- SRA 0x00032103, rt_data=0x80000000 -> code 000011, d1=0x80000000, d2=4, wr_addr=4.
- LUI 0x3C051234 -> code 100101, d1=0, d2=0x12340000, wr_addr=5. ADD with rd=0 -> wr_en=0. SW -> wr_en=0, code 100000.
- Load ADDI, then stall 3 cycles with different inputs -> outputs unchanged. Then stall+flush in the same cycle -> o_valid=0, all outputs 0.
- 300 consecutive 0xFC000000 with i_valid=1 -> o_illegal=1 each cycle, o_illegal_cnt saturates at 255. Check that 10 of those same illegal words presented on stall edges do not count.
- Reset asserted during a stream of valid instructions -> all outputs 0 on the next cycle. First instruction after reset deasserts appears 1 cycle later.
